// File: rtl/mult_rr_scheduler_if.sv
// mult_rr_scheduler_if
//   Bundles the client-side request/response handshake and the multiplier-side
//   issue/return signals of the round-robin multiplier scheduler.
//   slave  : the scheduler's view (drives grants, results, multiplier operands)
//   master : the environment's view (clients plus the multiplier instance)
// Signals
//   en            global enable
//   req_valid     per-requester request valid            [NREQ]
//   req_a/req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready     one-hot grant or zero                  [NREQ]
//   rsp_valid     one-hot result strobe                  [NREQ]
//   rsp_data      product returned with rsp_valid        [2*WIDTH]
//   mul_in1/in2   operands to the multiplier             [WIDTH]
//   mul_inValid   operand valid to the multiplier
//   mul_en        multiplier enable (mirrors en)
//   mul_out       product from the multiplier            [2*WIDTH]
//   mul_outValid  product valid from the multiplier
//   err           sticky protocol-error flag
interface mult_rr_scheduler_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   logic                   en;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*WIDTH-1:0]  req_a;
   logic [NREQ*WIDTH-1:0]  req_b;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ-1:0]        rsp_valid;
   logic [2*WIDTH-1:0]     rsp_data;
   logic [WIDTH-1:0]       mul_in1;
   logic [WIDTH-1:0]       mul_in2;
   logic                   mul_inValid;
   logic                   mul_en;
   logic [2*WIDTH-1:0]     mul_out;
   logic                   mul_outValid;
   logic                   err;

   modport slave (
      input  en, req_valid, req_a, req_b, mul_out, mul_outValid,
      output req_ready, rsp_valid, rsp_data, mul_in1, mul_in2, mul_inValid, mul_en, err
   );

   modport master (
      output en, req_valid, req_a, req_b, mul_out, mul_outValid,
      input  req_ready, rsp_valid, rsp_data, mul_in1, mul_in2, mul_inValid, mul_en, err
   );
endinterface

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
//   Shares one pipelined multiplier among NREQ requesters. A round-robin
//   arbiter grants one request per cycle, the winner's operands are registered
//   onto the multiplier inputs, and the winner's index is pushed into a tag
//   FIFO so each returning product can be steered back to its issuer.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous reset, active-low
//   bus    mult_rr_scheduler_if.slave (handshake, multiplier and err signals)
module mult_rr_scheduler #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int LAT   = 2,
   parameter int DEPTH = LAT + 1
) (
   input logic                clk,
   input logic                reset,
   mult_rr_scheduler_if.slave bus
);
   localparam int PW = $clog2(NREQ);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int step);
      int s;
      s = int'(base) + step;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   function automatic logic [AW-1:0] fifo_inc(input logic [AW-1:0] p);
      return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   logic [PW-1:0]        ptr;
   logic [PW-1:0]        win;
   logic [NREQ-1:0]      grant;
   logic                 accept;
   logic                 pop_ok;
   logic                 pop_empty;
   logic [CW-1:0]        cnt;
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [PW-1:0]        tags [DEPTH];
   logic [WIDTH-1:0]     in1_q;
   logic [WIDTH-1:0]     in2_q;
   logic                 inv_q;
   logic [NREQ-1:0]      rspv_q;
   logic [2*WIDTH-1:0]   rspd_q;
   logic                 err_q;

   // Scan from the farthest candidate back towards ptr so the one nearest
   // ptr (in wrap order) is the last assignment and therefore wins. The full
   // check deliberately uses the pre-pop count.
   always_comb begin
      grant = '0;
      win   = '0;
      if (bus.en && (cnt < FULL_CNT)) begin
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_idx(ptr, k)]) begin
               grant                   = '0;
               grant[wrap_idx(ptr, k)] = 1'b1;
               win                     = wrap_idx(ptr, k);
            end
         end
      end
   end

   assign accept    = |(grant & bus.req_valid);
   assign pop_ok    = bus.en && bus.mul_outValid && (cnt != '0);
   assign pop_empty = bus.en && bus.mul_outValid && (cnt == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr    <= '0;
         cnt    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int d = 0; d < DEPTH; d++) tags[d] <= '0;
         in1_q  <= '0;
         in2_q  <= '0;
         inv_q  <= 1'b0;
         rspv_q <= '0;
         rspd_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (pop_empty) err_q <= 1'b1;
         if (bus.en) begin
            if (accept) begin
               in1_q          <= bus.req_a[int'(win)*WIDTH +: WIDTH];
               in2_q          <= bus.req_b[int'(win)*WIDTH +: WIDTH];
               inv_q          <= 1'b1;
               tags[wr_ptr]   <= win;
               wr_ptr         <= fifo_inc(wr_ptr);
               ptr            <= wrap_idx(win, 1);
            end else begin
               inv_q <= 1'b0;
            end
            if (pop_ok) begin
               rspv_q <= {{(NREQ-1){1'b0}}, 1'b1} << tags[rd_ptr];
               rspd_q <= bus.mul_out;
               rd_ptr <= fifo_inc(rd_ptr);
            end else begin
               rspv_q <= '0;
            end
            case ({accept, pop_ok})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end
   end

   assign bus.req_ready   = grant;
   assign bus.rsp_valid   = rspv_q;
   assign bus.rsp_data    = rspd_q;
   assign bus.mul_in1     = in1_q;
   assign bus.mul_in2     = in2_q;
   assign bus.mul_inValid = inv_q;
   assign bus.mul_en      = bus.en;
   assign bus.err         = err_q;
endmodule
